// File: rtl/aes_pkg.sv
// Shared definitions for the AES mix-columns engines: field polynomial,
// column count, engine FSM states and the GF(2^8) xtime helper.
package aes_pkg;

  localparam logic [7:0] GF_POLY  = 8'h1b;
  localparam int         AES_COLS = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mix_state_e;

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational single-column InvMixColumns (and forward MixColumns when
// AES_MIX_FWD_EN is defined) built from chained xtime products.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
`ifdef AES_MIX_FWD_EN
  input  logic        fwd,
`endif
  output logic [31:0] col_out
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
  logic [7:0] b  [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = col_in[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  // Each output row rotates the coefficient row one byte to the right.
  always_comb begin
    col_out = '0;
    for (int i = 0; i < 4; i++) begin
      b[i] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
`ifdef AES_MIX_FWD_EN
      if (fwd) begin
        b[i] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
`endif
      col_out[31-8*i -: 8] = b[i];
    end
  end

endmodule

// File: rtl/aes_inv_mix_columns.sv
// Iterative InvMixColumns engine: one column per clock, valid/ready on both
// sides. Define AES_MIX_FWD_EN to add the fwd port and forward MixColumns.
module aes_inv_mix_columns
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_MIX_FWD_EN
  input  logic         fwd,
`endif
  output logic [127:0] out_data
);

  mix_state_e   state_cur, state_nxt;
  logic [127:0] state_q, state_upd;
  logic [1:0]   col_q;
  logic         load, upd;
  logic [31:0]  col_sel, col_res;

`ifdef AES_MIX_FWD_EN
  logic fwd_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_cur <= IDLE;
    end else begin
      state_cur <= state_nxt;
    end
  end

  // in_ready in DONE follows out_ready so a new state can enter on the same
  // edge that the finished one leaves.
  always_comb begin
    state_nxt = state_cur;
    in_ready  = 1'b0;
    load      = 1'b0;
    upd       = 1'b0;
    unique case (state_cur)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        upd = 1'b1;
        if (col_q == 2'(AES_COLS - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = BUSY;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    state_upd = state_q;
    col_sel   = state_q[127:96];
    case (col_q)
      2'd0: begin col_sel = state_q[127:96]; state_upd[127:96] = col_res; end
      2'd1: begin col_sel = state_q[95:64];  state_upd[95:64]  = col_res; end
      2'd2: begin col_sel = state_q[63:32];  state_upd[63:32]  = col_res; end
      default: begin col_sel = state_q[31:0]; state_upd[31:0] = col_res; end
    endcase
  end

  inv_mix_column u_col (
    .col_in  (col_sel),
`ifdef AES_MIX_FWD_EN
    .fwd     (fwd_q),
`endif
    .col_out (col_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      col_q   <= '0;
    end else if (load) begin
      state_q <= in_data;
      col_q   <= '0;
    end else if (upd) begin
      state_q <= state_upd;
      col_q   <= col_q + 2'd1;
    end
  end

`ifdef AES_MIX_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q <= 1'b0;
    end else if (load) begin
      fwd_q <= fwd;
    end
  end
`endif

  assign out_valid = (state_cur == DONE);
  assign out_data  = state_q;

endmodule
